// File: rtl/block_norm_scheduler.sv
// Sequencer for the block-normalization core: fetches each 2x2 cell block, runs the core, hands the block downstream.
// Optional done-flag watchdog enabled by defining BLOCK_NORM_SCHED_TIMEOUT_EN.
module block_norm_scheduler #(
  parameter int CELLS_X = 8,
  parameter int CELLS_Y = 16,
  parameter int ADDR_W  = 7,
  parameter int RD_LAT  = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                         iClk,
  input  logic                         iRst_n,
  input  logic                         iStart,
  input  logic                         iAbort,
  output logic                         oBusy,
  output logic                         oCellRd,
  output logic [ADDR_W-1:0]            oCellAddr,
  output logic                         oCapture,
  output logic [1:0]                   oCaptureSlot,
  output logic                         oNormStart,
  input  logic                         iNormDone,
  output logic                         oBlkValid,
  input  logic                         iBlkReady,
  output logic [$clog2(CELLS_X-1)-1:0] oBlkX,
  output logic [$clog2(CELLS_Y-1)-1:0] oBlkY,
  output logic                         oFrameDone,
  output logic                         oError
);

  localparam int BX_W = $clog2(CELLS_X-1);
  localparam int BY_W = $clog2(CELLS_Y-1);

  if (RD_LAT < 1 || RD_LAT > 4 || TIMEOUT < 1 || (1 << ADDR_W) < CELLS_X * CELLS_Y) begin : g_param_check
    $error("block_norm_scheduler: illegal parameter set");
  end

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT_RD, START, WAIT_NORM, EMIT, NEXT, DONE
  } state_t;

  // Tag travelling alongside each RAM read so the capture strobe lines up with returning data.
  typedef struct packed {
    logic       vld;
    logic [1:0] slot;
  } rd_tag_t;

  state_t          state_q, state_d;
  logic [BX_W-1:0] bx_q, bx_d;
  logic [BY_W-1:0] by_q, by_d;
  logic [1:0]      slot_q, slot_d;
  rd_tag_t         rd_pipe_q [RD_LAT];

`ifdef BLOCK_NORM_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            err_q, err_d;
`endif

  assign oBusy        = (state_q != IDLE);
  assign oBlkX        = bx_q;
  assign oBlkY        = by_q;
  assign oCapture     = rd_pipe_q[RD_LAT-1].vld;
  assign oCaptureSlot = rd_pipe_q[RD_LAT-1].slot;

  // Slot bit 0 steps one cell right, slot bit 1 steps one cell down.
  always_comb begin
    oCellAddr = '0;
    if (oCellRd) begin
      oCellAddr = ADDR_W'((int'(by_q) + int'(slot_q[1])) * CELLS_X + int'(bx_q) + int'(slot_q[0]));
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no branch can leave one unassigned and infer a latch.
    state_d    = state_q;
    bx_d       = bx_q;
    by_d       = by_q;
    slot_d     = slot_q;
    oCellRd    = 1'b0;
    oNormStart = 1'b0;
    oBlkValid  = 1'b0;
    oFrameDone = 1'b0;
`ifdef BLOCK_NORM_SCHED_TIMEOUT_EN
    wd_cnt_d   = wd_cnt_q;
    err_d      = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (iStart) begin
          bx_d    = '0;
          by_d    = '0;
          slot_d  = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        oCellRd = 1'b1;
        slot_d  = slot_q + 2'd1;
        if (slot_q == 2'd3) state_d = WAIT_RD;
      end
      WAIT_RD: begin
        if (oCapture && oCaptureSlot == 2'd3) state_d = START;
      end
      START: begin
        oNormStart = 1'b1;
        state_d    = WAIT_NORM;
`ifdef BLOCK_NORM_SCHED_TIMEOUT_EN
        wd_cnt_d   = '0;
`endif
      end
      WAIT_NORM: begin
        if (iNormDone) begin
          state_d = EMIT;
        end
`ifdef BLOCK_NORM_SCHED_TIMEOUT_EN
        else if (wd_cnt_q == WD_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
`endif
      end
      EMIT: begin
        oBlkValid = 1'b1;
        if (iBlkReady) state_d = NEXT;
      end
      NEXT: begin
        slot_d = '0;
        if (bx_q == BX_W'(CELLS_X - 2)) begin
          if (by_q == BY_W'(CELLS_Y - 2)) begin
            state_d = DONE;
          end else begin
            bx_d    = '0;
            by_d    = by_q + 1'b1;
            state_d = FETCH;
          end
        end else begin
          bx_d    = bx_q + 1'b1;
          state_d = FETCH;
        end
      end
      DONE: begin
        oFrameDone = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (iAbort) state_d = IDLE;
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= IDLE;
      bx_q    <= '0;
      by_q    <= '0;
      slot_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of statement order.
      state_q <= state_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      slot_q  <= slot_d;
    end
  end

  // NOTE: the read pipeline is a handful of flops, not a RAM, so resetting and flushing it costs nothing.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int i = 0; i < RD_LAT; i++) rd_pipe_q[i] <= '0;
    end else if (iAbort) begin
      for (int i = 0; i < RD_LAT; i++) rd_pipe_q[i] <= '0;
    end else begin
      rd_pipe_q[0] <= rd_tag_t'{vld: oCellRd, slot: slot_q};
      for (int i = 1; i < RD_LAT; i++) rd_pipe_q[i] <= rd_pipe_q[i-1];
    end
  end

`ifdef BLOCK_NORM_SCHED_TIMEOUT_EN
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      err_q    <= err_d;
    end
  end

  assign oError = err_q;
`else
  assign oError = 1'b0;
`endif

endmodule
